// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone SRAM controller.
// Holds CSR bit positions, macro geometry, the access FSM state type and
// the sampled Wishbone request payload.
package wb_sram_pkg;

    localparam int unsigned MACRO_DEPTH = 1024;
    localparam int unsigned MACRO_AW    = 10;
    localparam int unsigned ROW_W       = 2;
    localparam int unsigned CLR_CNT_W   = 12;

    localparam logic [31:0] CSR_OFFSET_DEFAULT = 32'h0001_0000;

    localparam int unsigned CSR_CLEAR_BIT  = 0;
    localparam int unsigned CSR_IRQ_EN_BIT = 1;
    localparam int unsigned CSR_BUSY_BIT   = 8;
    localparam int unsigned CSR_ERR_BIT    = 9;
    localparam int unsigned CSR_DONE_BIT   = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HIT_MISS = 2'd0,
        HIT_MEM  = 2'd1,
        HIT_CSR  = 2'd2
    } hit_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_req_t;

    // CSR read image; CLEAR always reads back as 0.
    function automatic logic [31:0] csr_pack(input logic irq_en, input logic busy,
                                             input logic err, input logic done);
        logic [31:0] v;
        v = '0;
        v[CSR_IRQ_EN_BIT] = irq_en;
        v[CSR_BUSY_BIT]   = busy;
        v[CSR_ERR_BIT]    = err;
        v[CSR_DONE_BIT]   = done;
        return v;
    endfunction

endpackage

// File: rtl/wb_sram_clear.sv
// Clear engine: walks every word of the memory once, one word per cycle.
// Ports: clk/rst (async active-high), start (begin a sweep when idle),
//        busy (sweep in progress), cnt (current word index),
//        done_c (high while the last word is being issued).
module wb_sram_clear
    import wb_sram_pkg::*;
#(
    parameter int unsigned ROWS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic [CLR_CNT_W-1:0] cnt,
    output logic                 done_c
);

    localparam logic [CLR_CNT_W-1:0] LAST_WORD = CLR_CNT_W'(ROWS * MACRO_DEPTH - 1);

    assign done_c = busy && (cnt == LAST_WORD);

    // A start request while busy is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            if (cnt == LAST_WORD) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CLR_CNT_W'(1);
            end
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave in front of ROWS x DATA_BYTES external 1024x8 SRAM
// macros, with a control/status register and a memory clear engine.
// Ports: wb_clk_i/wb_rst_i (async active-high), wbs_* Wishbone slave,
//        sram_* shared macro address/data/mask plus per-macro enables,
//        sram_q macro read data, irq[0] clear-done interrupt.
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ROWS       = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [31:0] CSR_OFFSET = CSR_OFFSET_DEFAULT
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    input  logic [3:0]                   wbs_sel_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    output logic [MACRO_AW-1:0]          sram_a,
    output logic [8*DATA_BYTES-1:0]      sram_d,
    output logic [ROWS*DATA_BYTES-1:0]   sram_cen_n,
    output logic [ROWS*DATA_BYTES-1:0]   sram_gwen_n,
    output logic [8*DATA_BYTES-1:0]      sram_wen_n,
    input  logic [ROWS*8*DATA_BYTES-1:0] sram_q,
    output logic [2:0]                   irq
);

    localparam int unsigned LANE_W  = 8 * DATA_BYTES;
    localparam int unsigned NMAC    = ROWS * DATA_BYTES;
    localparam int unsigned LANE_SH = $clog2(DATA_BYTES);
    localparam logic [32:0] MEM_END = 33'(BASE_ADDR) + 33'(ROWS * MACRO_DEPTH * DATA_BYTES);
    localparam logic [31:0] CSR_ADDR = BASE_ADDR + CSR_OFFSET;

    // Per-macro mask with the given lanes set in the selected row only.
    function automatic logic [NMAC-1:0] row_mask(input logic [ROW_W-1:0]      row,
                                                 input logic [DATA_BYTES-1:0] lanes);
        logic [NMAC-1:0] m;
        m = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row == ROW_W'(r)) m[r*DATA_BYTES +: DATA_BYTES] = lanes;
        end
        return m;
    endfunction

    // Expand byte selects to a per-bit mask.
    function automatic logic [LANE_W-1:0] lane_bits(input logic [DATA_BYTES-1:0] lanes);
        logic [LANE_W-1:0] m;
        m = '0;
        for (int l = 0; l < int'(DATA_BYTES); l++) begin
            m[l*8 +: 8] = {8{lanes[l]}};
        end
        return m;
    endfunction

    state_t                 state_q, state_d;
    wb_req_t                req_c;
    hit_t                   hit_c;
    logic [31:0]            off_c, idx_c;
    logic [ROW_W-1:0]       row_c;
    logic [DATA_BYTES-1:0]  sel_c;
    logic [LANE_W-1:0]      q_row_c;
    logic                   unused_bits;

    logic                   ack_d;
    logic [31:0]            dat_d;
    logic [MACRO_AW-1:0]    a_d;
    logic [LANE_W-1:0]      d_d, wen_d;
    logic [NMAC-1:0]        cen_d, gwen_d;
    logic [2:0]             irq_d;
    logic                   irq_en_q, irq_en_d;
    logic                   err_q, err_d, err_set_c, err_clr_c;
    logic                   done_q, done_d, done_clr_c;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   we_q, we_d;

    logic                   clr_start_c;
    logic                   clr_busy;
    logic [CLR_CNT_W-1:0]   clr_cnt;
    logic                   clr_done_c;

    wb_sram_clear #(
        .ROWS (ROWS)
    ) u_clear (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .start  (clr_start_c),
        .busy   (clr_busy),
        .cnt    (clr_cnt),
        .done_c (clr_done_c)
    );

    assign req_c = '{we: wbs_we_i, adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i};
    assign off_c = req_c.adr - BASE_ADDR;
    assign idx_c = off_c >> LANE_SH;
    assign row_c = idx_c[MACRO_AW +: ROW_W];
    assign sel_c = req_c.sel[DATA_BYTES-1:0];
    assign unused_bits = ^idx_c[31:MACRO_AW+ROW_W];

    // Address decode; the CSR address wins if it ever overlaps the window.
    always_comb begin
        hit_c = HIT_MISS;
        if (req_c.adr == CSR_ADDR) begin
            hit_c = HIT_CSR;
        end else if ((req_c.adr >= BASE_ADDR) && (33'(req_c.adr) < MEM_END)) begin
            hit_c = HIT_MEM;
        end
    end

    // Read data of the row captured at request time.
    always_comb begin
        q_row_c = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_q == ROW_W'(r)) q_row_c = sram_q[r*LANE_W +: LANE_W];
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_d       = '0;
        cen_d       = '1;
        gwen_d      = '1;
        wen_d       = '1;
        a_d         = sram_a;
        d_d         = sram_d;
        row_d       = row_q;
        we_d        = we_q;
        irq_en_d    = irq_en_q;
        err_set_c   = 1'b0;
        err_clr_c   = 1'b0;
        done_clr_c  = 1'b0;
        clr_start_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    case (hit_c)
                        HIT_CSR: begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                            if (req_c.we) begin
                                if (req_c.sel[0]) begin
                                    irq_en_d    = req_c.dat[CSR_IRQ_EN_BIT];
                                    clr_start_c = req_c.dat[CSR_CLEAR_BIT] && !clr_busy;
                                end
                                if (req_c.sel[1]) begin
                                    err_clr_c  = req_c.dat[CSR_ERR_BIT];
                                    done_clr_c = req_c.dat[CSR_DONE_BIT];
                                end
                            end else begin
                                dat_d = csr_pack(irq_en_q, clr_busy, err_q, done_q);
                            end
                        end
                        HIT_MEM: begin
                            // Held off in IDLE until the clear sweep finishes.
                            if (!clr_busy) begin
                                state_d = ST_ACCESS;
                                row_d   = row_c;
                                we_d    = req_c.we;
                                a_d     = idx_c[MACRO_AW-1:0];
                                cen_d   = ~row_mask(row_c, '1);
                                if (req_c.we) begin
                                    d_d    = req_c.dat[LANE_W-1:0];
                                    gwen_d = ~row_mask(row_c, sel_c);
                                    wen_d  = ~lane_bits(sel_c);
                                end
                            end
                        end
                        default: begin
                            state_d   = ST_ACK;
                            ack_d     = 1'b1;
                            err_set_c = 1'b1;
                        end
                    endcase
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                dat_d   = 32'(q_row_c);
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear sweep owns the macro pins; no memory access overlaps it.
        if (clr_busy) begin
            a_d    = clr_cnt[MACRO_AW-1:0];
            d_d    = '0;
            cen_d  = ~row_mask(clr_cnt[MACRO_AW +: ROW_W], '1);
            gwen_d = cen_d;
            wen_d  = '0;
        end

        // Set events take priority over a same-cycle W1C.
        err_d  = err_set_c || (err_q && !err_clr_c);
        done_d = clr_done_c || (done_q && !done_clr_c);
        irq_d  = {2'b00, done_d && irq_en_d};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            sram_a      <= '0;
            sram_d      <= '0;
            sram_cen_n  <= '1;
            sram_gwen_n <= '1;
            sram_wen_n  <= '1;
            irq         <= '0;
            irq_en_q    <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            row_q       <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wbs_ack_o   <= ack_d;
            wbs_dat_o   <= dat_d;
            sram_a      <= a_d;
            sram_d      <= d_d;
            sram_cen_n  <= cen_d;
            sram_gwen_n <= gwen_d;
            sram_wen_n  <= wen_d;
            irq         <= irq_d;
            irq_en_q    <= irq_en_d;
            err_q       <= err_d;
            done_q      <= done_d;
            row_q       <= row_d;
            we_q        <= we_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl with two macro rows and a behavioural
// model of the external 1024x8 macros.
module tb_wb_sram_ctrl;

    localparam int unsigned DB     = 4;
    localparam int unsigned ROWS   = 2;
    localparam int unsigned NMAC   = ROWS * DB;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] CSR    = BASE + 32'h0001_0000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]            adr = '0, wdat = '0;
    logic [3:0]             sel = '0;
    logic                   ack;
    logic [31:0]            rdat_o;
    logic [9:0]             sram_a;
    logic [8*DB-1:0]        sram_d, sram_wen_n;
    logic [NMAC-1:0]        sram_cen_n, sram_gwen_n;
    logic [ROWS*8*DB-1:0]   sram_q = '0;
    logic [2:0]             irq;

    int                     checks = 0;
    int                     errors = 0;

    logic [31:0]            rdata;
    int                     lat;
    logic [NMAC-1:0]        cen_acc, gwen_acc;
    logic                   ack_after;

    logic [7:0]             mem [NMAC][1024];

    wb_sram_ctrl #(
        .DATA_BYTES (DB),
        .ROWS       (ROWS),
        .BASE_ADDR  (BASE),
        .CSR_OFFSET (32'h0001_0000)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_sel_i   (sel),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat_o),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .sram_cen_n  (sram_cen_n),
        .sram_gwen_n (sram_gwen_n),
        .sram_wen_n  (sram_wen_n),
        .sram_q      (sram_q),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Macro model: synchronous, bit-masked write, registered read data.
    always @(posedge clk) begin
        for (int m = 0; m < int'(NMAC); m++) begin
            if (!sram_cen_n[m]) begin
                if (!sram_gwen_n[m]) begin
                    mem[m][sram_a] <= (mem[m][sram_a] & sram_wen_n[(m%DB)*8 +: 8]) |
                                      (sram_d[(m%DB)*8 +: 8] & ~sram_wen_n[(m%DB)*8 +: 8]);
                end else begin
                    sram_q[m*8 +: 8] <= mem[m][sram_a];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone classic transfer; latency counted in edges from request.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        logic got;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0; cen_acc = '1; gwen_acc = '1; rdata = '0; got = 1'b0;
        while (!got && lat < 5000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cen_acc  = cen_acc & sram_cen_n;
            gwen_acc = gwen_acc & sram_gwen_n;
            if (ack) begin
                rdata = rdat_o;
                got   = 1'b1;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        @(negedge clk);
        ack_after = ack;
    endtask

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack",  32'(ack), 32'h0);
        check("rst_dat",  rdat_o, 32'h0);
        check("rst_cen",  32'(sram_cen_n), 32'hFF);
        check("rst_gwen", 32'(sram_gwen_n), 32'hFF);
        check("rst_wen",  sram_wen_n, 32'hFFFF_FFFF);
        check("rst_a",    32'(sram_a), 32'h0);
        check("rst_irq",  32'(irq), 32'h0);
        rst = 1'b0;

        // Full-word write and read back.
        bus(1'b1, BASE + 32'h10, 32'hA5A5_1234, 4'hF);
        check("wr_lat",  32'(lat), 32'd2);
        check("wr_cen",  32'(cen_acc), 32'hF0);
        check("wr_gwen", 32'(gwen_acc), 32'hF0);
        check("wr_ack1", 32'(ack_after), 32'h0);
        bus(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        check("rd_lat",  32'(lat), 32'd3);
        check("rd_data", rdata, 32'hA5A5_1234);
        check("rd_ack1", 32'(ack_after), 32'h0);

        // Single-lane write.
        bus(1'b1, BASE + 32'h10, 32'h0000_FF00, 4'b0010);
        check("bw_gwen", 32'(gwen_acc), 32'hFD);
        bus(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        check("bw_data", rdata, 32'hA5A5_FF34);

        // Miss past the end of the window.
        bus(1'b0, BASE + 32'h2000, 32'h0, 4'hF);
        check("miss_lat",  32'(lat), 32'd1);
        check("miss_data", rdata, 32'h0);
        check("miss_cen",  32'(cen_acc), 32'hFF);
        bus(1'b0, CSR, 32'h0, 4'hF);
        check("csr_lat", 32'(lat), 32'd1);
        check("csr_err", rdata, 32'h0000_0200);
        bus(1'b1, CSR, 32'h0000_0200, 4'hF);
        bus(1'b0, CSR, 32'h0, 4'hF);
        check("csr_w1c", rdata, 32'h0);

        // Row boundary: last word of row 0, first word of row 1.
        bus(1'b1, BASE + 32'h0FFC, 32'h1111_2222, 4'hF);
        check("r0_cen", 32'(cen_acc), 32'hF0);
        check("r0_a",   32'(sram_a), 32'h3FF);
        bus(1'b1, BASE + 32'h1000, 32'h3333_4444, 4'hF);
        check("r1_cen", 32'(cen_acc), 32'h0F);
        bus(1'b0, BASE + 32'h0FFC, 32'h0, 4'hF);
        check("r0_data", rdata, 32'h1111_2222);
        bus(1'b0, BASE + 32'h1000, 32'h0, 4'hF);
        check("r1_data", rdata, 32'h3333_4444);

        // Clear sweep with interrupt enabled.
        bus(1'b1, CSR, 32'h0000_0003, 4'hF);
        bus(1'b0, CSR, 32'h0, 4'hF);
        check("clr_busy", rdata, 32'h0000_0102);
        check("clr_irq0", 32'(irq), 32'h0);
        bus(1'b0, BASE + 32'h10, 32'h0, 4'hF);
        check("clr_stall", 32'((lat > 2000) && (lat < 2100)), 32'h1);
        check("clr_rd0",  rdata, 32'h0);
        bus(1'b0, CSR, 32'h0, 4'hF);
        check("clr_done", rdata, 32'h0000_0402);
        check("clr_irq1", 32'(irq), 32'h1);
        bus(1'b0, BASE + 32'h1000, 32'h0, 4'hF);
        check("clr_rd1",  rdata, 32'h0);
        bus(1'b1, CSR, 32'h0000_0402, 4'hF);
        check("done_w1c_irq", 32'(irq), 32'h0);
        bus(1'b0, CSR, 32'h0, 4'hF);
        check("done_w1c", rdata, 32'h0000_0002);

        // Reset in the middle of a sweep.
        bus(1'b1, CSR, 32'h0000_0003, 4'hF);
        repeat (10) @(negedge clk);
        check("mid_cen", 32'(sram_cen_n), 32'hF0);
        rst = 1'b1;
        #1;
        check("mr_ack",  32'(ack), 32'h0);
        check("mr_dat",  rdat_o, 32'h0);
        check("mr_cen",  32'(sram_cen_n), 32'hFF);
        check("mr_gwen", 32'(sram_gwen_n), 32'hFF);
        check("mr_wen",  sram_wen_n, 32'hFFFF_FFFF);
        check("mr_a",    32'(sram_a), 32'h0);
        check("mr_d",    sram_d, 32'h0);
        check("mr_irq",  32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, CSR, 32'h0, 4'hF);
        check("mr_csr", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, meaning byte lanes per word (1, 2 or 4); one 1024x8 SRAM macro per lane.
REQ-002 SHALL have parameter ROWS, default 1, meaning macro rows stacked for depth (1..4); depth = ROWS*1024 words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning Wishbone byte base of the memory window.
REQ-004 SHALL have parameter CSR_OFFSET, default 32'h0001_0000, meaning byte offset of the control/status register from BASE_ADDR.
REQ-005 SHALL have ports wb_clk_i  in  1  sole clock; wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic request qualifiers.
REQ-007 SHALL have ports wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data; wbs_sel_i  in  4  byte select.
REQ-008 SHALL have ports wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-009 SHALL have ports sram_a  out  10  shared macro address; sram_d  out  8*DATA_BYTES  shared write data.
REQ-010 SHALL have ports sram_cen_n  out  ROWS*DATA_BYTES  per-macro chip enable, active-low; sram_gwen_n  out  ROWS*DATA_BYTES  per-macro global write enable, active-low.
REQ-011 SHALL have ports sram_wen_n  out  8*DATA_BYTES  shared bit write mask, active-low; sram_q  in  ROWS*8*DATA_BYTES  macro read data, valid the cycle after a read edge.
REQ-012 SHALL have port irq  out  3  user interrupts; irq[0] clear-done, irq[2:1] tied 0.

Function
REQ-013 SHALL decode: MEM hit when BASE_ADDR <= adr < BASE_ADDR+ROWS*1024*DATA_BYTES; CSR hit when adr == BASE_ADDR+CSR_OFFSET; otherwise MISS.
REQ-014 SHALL form word index = (adr-BASE_ADDR)/DATA_BYTES; sram_a = index[9:0], row = index/1024.
REQ-015 SHALL run access FSM IDLE -> ACCESS -> (read: CAPTURE) -> ACK -> IDLE, sampling adr/dat/sel/we in IDLE when cyc&stb.
REQ-016 SHALL in ACCESS assert cen_n=0 only for macros of the selected row; on write, gwen_n=0 for lanes with sel set, wen_n=0 on those lanes' bits.
REQ-017 SHALL give latency from request cycle to ack: write 2 cycles, read 3 cycles; wbs_ack_o high exactly one cycle; wbs_dat_o valid in the ack cycle, upper lanes beyond DATA_BYTES read 0.
REQ-018 SHALL never start a new access in the ack cycle; a request still held after ack is treated as new only once FSM is back in IDLE.
REQ-019 SHALL ack MISS in 1 cycle with wbs_dat_o=0, no macro enabled, and set ERR sticky.
REQ-020 SHALL ack CSR accesses in 1 cycle: bit0 CLEAR (W1 starts, reads 0), bit1 IRQ_EN (RW), bit8 BUSY (RO), bit9 ERR (W1C), bit10 DONE (W1C).
REQ-021 SHALL on CLEAR write with BUSY=0 start clear engine: counter 0..ROWS*1024-1, one word per cycle, all lanes of the row written 0; CLEAR while BUSY ignored.
REQ-022 SHALL stall MEM requests while BUSY (no ack until clear ends); CSR and MISS requests serviced during clear.
REQ-023 SHALL at last clear word set DONE, drop BUSY the next cycle; irq[0] = DONE & IRQ_EN.
REQ-024 SHALL give W1C of ERR/DONE in same cycle as a new set event priority to the set.

Reset
REQ-025 SHALL on wb_rst_i high asynchronously force: FSM IDLE, wbs_ack_o=0, wbs_dat_o=0, all cen_n/gwen_n/wen_n=1, sram_a=0, sram_d=0, CSR=0, clear counter 0, irq=0.
REQ-026 SHALL on reset mid-access or mid-clear abandon the operation with no ack; memory contents undefined for the in-flight word.

Structure
REQ-027 SHALL place CSR bit positions, CSR_OFFSET default, macro depth 1024 and FSM state typedef in shared package wb_sram_pkg.
REQ-028 SHALL implement the clear engine as sub-module wb_sram_clear (counter, BUSY, done pulse); macros are external.

Verification
REQ-029 SHALL cover: write 0xA5A5_1234 sel=F to BASE+0x10, read back -> ack at cycle 2 and 3 resp., data 0xA5A5_1234.
REQ-030 SHALL cover: then write 0x0000_FF00 sel=0010 to BASE+0x10 -> read 0xA5A5_FF34, only lane1 gwen_n low.
REQ-031 SHALL cover: read BASE+ROWS*4096 -> 1-cycle ack, data 0, CSR bit9=1; W1C 0x200 -> ERR=0.
REQ-032 SHALL cover: CSR write 0x3 -> BUSY=1, MEM read stalled, after ROWS*1024 cycles DONE=1, irq[0]=1, read returns 0.
REQ-033 SHALL cover: ROWS=2, write last word row0 and first word row1 -> distinct cen_n bits, both read back intact.
REQ-034 SHALL cover: wb_rst_i asserted while BUSY -> all outputs at reset values same cycle, BUSY=0, irq=0.
